// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates ALU results and load responses into a single
// registered register-bank write port, formatting loads and flagging bad ones.
module writeback_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_val,
  output logic        alu_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        reg_we,
  output logic [4:0]  rd,
  output logic [31:0] rd_val,
  output logic        ld_err
);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_LD
  } grant_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  grant_e      grant;
  logic [1:0]  starve_q, starve_d;
  logic        we_q, we_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] val_q, val_d;
  logic        err_q, err_d;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;
  logic        ld_bad;

  // Load wins conflicts unless the ALU has already lost three in a row.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    grant = GNT_NONE;
    if (!rst) begin
      if (alu_valid && ld_valid) begin
        grant = (starve_q == 2'd3) ? GNT_ALU : GNT_LD;
      end else if (alu_valid) begin
        grant = GNT_ALU;
      end else if (ld_valid) begin
        grant = GNT_LD;
      end
    end
  end

  assign alu_ready = (grant == GNT_ALU);
  assign ld_ready  = (grant == GNT_LD);

  always_comb begin
    starve_d = 2'd0;
    if (alu_valid && !alu_ready) begin
      starve_d = starve_q + 2'd1;
    end
  end

  always_comb begin
    ld_byte = ld_data[7:0];
    case (ld_addr_lo)
      2'd0: ld_byte = ld_data[7:0];
      2'd1: ld_byte = ld_data[15:8];
      2'd2: ld_byte = ld_data[23:16];
      2'd3: ld_byte = ld_data[31:24];
      default: ld_byte = ld_data[7:0];
    endcase
  end

  assign ld_half = ld_addr_lo[1] ? ld_data[31:16] : ld_data[15:0];

  always_comb begin
    ld_fmt = 32'd0;
    ld_bad = 1'b0;
    case (ld_funct3)
      F3_LB:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU: ld_fmt = {24'd0, ld_byte};
      F3_LH: begin
        ld_fmt = {{16{ld_half[15]}}, ld_half};
        ld_bad = ld_addr_lo[0];
      end
      F3_LHU: begin
        ld_fmt = {16'd0, ld_half};
        ld_bad = ld_addr_lo[0];
      end
      F3_LW: begin
        ld_fmt = ld_data;
        ld_bad = (ld_addr_lo != 2'd0);
      end
      default: ld_bad = 1'b1;
    endcase
  end

  // Writes to x0 and faulted loads still update rd/rd_val but never assert reg_we.
  always_comb begin
    we_d  = 1'b0;
    err_d = 1'b0;
    rd_d  = rd_q;
    val_d = val_q;
    case (grant)
      GNT_ALU: begin
        rd_d  = alu_rd;
        val_d = alu_val;
        we_d  = (alu_rd != 5'd0);
      end
      GNT_LD: begin
        rd_d  = ld_rd;
        val_d = ld_fmt;
        we_d  = (ld_rd != 5'd0) && !ld_bad;
        err_d = ld_bad;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      starve_q <= 2'd0;
      we_q     <= 1'b0;
      rd_q     <= 5'd0;
      val_q    <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      val_q    <= val_d;
      err_q    <= err_d;
    end
  end

  assign reg_we = we_q;
  assign rd     = rd_q;
  assign rd_val = val_q;
  assign ld_err = err_q;

endmodule
